addsub_4bit_ser: RTL and testbench
==================================

# addsub_4bit_ser

Bit-serial adder/subtractor that computes `a ± b` with carry/borrow-in, one bit per clock, LSB first, through a single full-adder cell. It complements the parallel ripple adder in the same lab: it computes both directions (add and subtract) but trades latency for area. A start/busy/done handshake sits between the operand source (switches or a counter) and the result display.

## Interface
- `W`, default 4: operand and result width, ≥2.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `sub`  in  1  0 = add, 1 = subtract; latched with `start`.
- `a`  in  W  operand A (two's complement or unsigned); latched with `start`.
- `b`  in  W  operand B; latched with `start`.
- `ci`  in  1  carry-in (add) or borrow-in (sub); latched with `start`.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; result valid.
- `so`  out  W  sum/difference.
- `co`  out  1  carry-out (add) or borrow-out (sub).
- `ov`  out  1  signed overflow.

## Operation
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Arithmetic:
  - add: `{co,so} = a + b + ci`.
  - sub: `so = a − b − ci` (mod 2^W), `co` = borrow-out.
  - Internally, sub is formed as `a + ~b + ~ci`. The raw carry-out is inverted to give the borrow.
- Overflow: `ov` = carry into MSB XOR raw carry out of MSB, in both modes.
- States:
  - IDLE → RUN when `start`=1. On this transition, latch `a` and `b^{W{sub}}` into shift registers, load the carry flop with `ci^sub`, clear the bit counter, and latch `sub`.
  - RUN: each cycle the full-adder cell consumes bit 0 of both shift registers and the carry flop. The sum bit shifts into the MSB of the result register, both operand registers shift right, the carry flop updates, and the counter increments. Before updating the carry flop, save its value (the carry into the MSB) at counter = W−1.
  - RUN → DONE after the cycle with counter = W−1. On this edge, register `so`, `co` (raw carry XOR latched `sub`) and `ov`.
  - DONE → IDLE unconditionally after one cycle.
- `start` is ignored in RUN and DONE; no queuing. If `start` is held high, the next operation is accepted on the first IDLE cycle.
- `so`, `co` and `ov` hold their last result until the next DONE overwrites them. They do not change during RUN.
- Input operands may change freely after the start edge.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `so`=0, `co`=0, `ov`=0; all internal registers cleared.
- Latency:
  - Start sampled at edge E0.
  - RUN occupies edges E1..EW.
  - `done`=1 and the result is valid in the cycle following edge EW; `done` falls at EW+1.
  - For W=4, `done` is high in the 5th cycle after the start edge.
- `busy` rises in the cycle after E0 and falls together with `done`.
- Throughput: one operation per W+2 cycles with `start` held high.
- `rst_n` asserted mid-RUN or in DONE:
  - Immediately forces IDLE and zeroes all outputs, without waiting for a clock.
  - The aborted operation produces no `done`.
  - The first edge after `rst_n` deasserts may accept `start`.
- Bit counter width: clog2(W). It never wraps in RUN, because the exit happens at W−1.

## Structure
- Shared package `fa_pkg`: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default width `FA_W=4`.
- Sub-module `fa_1bit` (ports `a`, `b`, `ci`, `so`, `co`): `so = a^b^ci`, `co` = majority. It is the only arithmetic in the block and is instantiated once.
- Top level: FSM, operand/result shift registers, carry flop, bit counter, output registers.

## Test plan
- Add, a=2, b=5, ci=0, W=4 → `so`=7, `co`=0, `ov`=0; `done` high in the 5th cycle after the start edge; `busy` high for 5 cycles.
- Add with carry and overflow:
  - a=15, b=1, ci=0 → `so`=0, `co`=1, `ov`=0.
  - a=7, b=1 → `so`=8, `co`=0, `ov`=1.
  - a=3, b=4, ci=1 → `so`=8, `ov`=1.
- Subtract:
  - a=5, b=3, ci=0 → `so`=2, `co`=0, `ov`=0.
  - a=3, b=5 → `so`=14, `co`=1, `ov`=0.
  - a=8, b=1 → `so`=7, `co`=0, `ov`=1.
  - a=5, b=3, ci=1 → `so`=1, `co`=0.
- Pulse `start` with a=9, b=9 during RUN of the a=2, b=5 add → ignored; result 7; exactly one `done`.
- Assert `rst_n`=0 for 3 ns after the 2nd RUN edge → `busy`, `done`, `so`, `co` and `ov` drop to 0 before the next edge; no `done`. Then start a=1, b=1 → `so`=2 with normal latency.
- Hold `start`=1 with a=2, b=5 stable → `done` pulses every 6 cycles; `so`=7 stays stable between pulses.

Source files
------------

// File: rtl/fa_pkg.sv
// Shared definitions for the bit-serial add/subtract block: default width and
// FSM state encoding.
package fa_pkg;

    localparam int FA_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_1bit.sv
// Single full-adder cell; the only arithmetic in the serial adder/subtractor.
module fa_1bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic so,
    output logic co
);

    assign so = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/addsub_4bit_ser.sv
// Bit-serial a +/- b with carry/borrow-in, LSB first through one full adder.
// Handshake: start is taken only in IDLE; done pulses one cycle with the result.
module addsub_4bit_ser
    import fa_pkg::*;
#(
    parameter int W = FA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] so,
    output logic         co,
    output logic         ov,
    output logic [1:0]   dbg_state
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_res;
    logic          r_c;
    logic          r_sub;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic [W-1:0]  r_so;
    logic          r_co;
    logic          r_ov;

    logic          w_sum;
    logic          w_cout;
    logic [W-1:0]  w_res_next;

    fa_1bit u_fa (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_c),
        .so (w_sum),
        .co (w_cout)
    );

    assign w_res_next = {w_sum, r_res[W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_sub   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_so    <= '0;
            r_co    <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + ~borrow_in through the same cell.
                        r_a     <= a;
                        r_b     <= b ^ {W{sub}};
                        r_c     <= ci ^ sub;
                        r_sub   <= sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res <= w_res_next;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_cout;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        // r_c here is the carry into the MSB.
                        r_so    <= w_res_next;
                        r_co    <= w_cout ^ r_sub;
                        r_ov    <= r_c ^ w_cout;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign so        = r_so;
    assign co        = r_co;
    assign ov        = r_ov;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_addsub_4bit_ser.sv
// Directed bench for addsub_4bit_ser: driver tasks push expected results into
// a queue, a negedge monitor pops and compares on every done pulse.
module tb_addsub_4bit_ser;

    localparam int W  = 4;
    localparam int EW = W + 2;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] so;
    logic         co;
    logic         ov;
    logic [1:0]   dbg_state;

    logic [EW-1:0] exp_q[$];
    int            errors;
    int            checks;
    int            n_pushed;
    int            n_done;
    int            cyc;
    int            done_cyc[$];

    addsub_4bit_ser #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .busy      (busy),
        .done      (done),
        .so        (so),
        .co        (co),
        .ov        (ov),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [EW-1:0] e;
            n_done++;
            done_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got so=%0d co=%0d ov=%0d with no expectation", so, co, ov);
            end else begin
                e = exp_q.pop_front();
                if ({so, co, ov} !== e) begin
                    errors++;
                    $display("FAIL result: got so=%0d co=%0d ov=%0d expected so=%0d co=%0d ov=%0d",
                             so, co, ov, e[EW-1:2], e[1], e[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input int eso, input bit eco, input bit eov);
        logic [W-1:0] s;
        s = W'(eso);
        exp_q.push_back({s, eco, eov});
        n_pushed++;
    endtask

    // Issue one operation; optionally pulse a stray start during RUN.
    task automatic run_op(input int ia, input int ib, input bit ici, input bit isub,
                          input int eso, input bit eco, input bit eov,
                          input bit intrude, input string name);
        int n;
        @(negedge clk);
        a = W'(ia); b = W'(ib); ci = ici; sub = isub; start = 1'b1;
        push_exp(eso, eco, eov);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom_range(0, 15)); b = W'($urandom_range(0, 15));
        ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        chk({name, "_busy_rise"}, busy, 1);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (intrude && n == 2) begin
                start = 1'b1; a = 4'd9; b = 4'd9; sub = 1'b0; ci = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({name, "_latency"}, n, 5);
        chk({name, "_busy_with_done"}, busy, 1);
        @(negedge clk);
        chk({name, "_done_fall"}, done, 0);
        chk({name, "_busy_fall"}, busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        errors = 0; checks = 0; n_pushed = 0; n_done = 0; cyc = 0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_so", so, 0);
        chk("rst_co", co, 0);
        chk("rst_ov", ov, 0);
        chk("rst_state", dbg_state, 0);
        rst_n = 1'b1;

        // add
        run_op(2, 5, 0, 0, 7, 0, 0, 0, "add_2_5");
        run_op(15, 1, 0, 0, 0, 1, 0, 0, "add_15_1");
        run_op(7, 1, 0, 0, 8, 0, 1, 0, "add_7_1");
        run_op(3, 4, 1, 0, 8, 0, 1, 0, "add_3_4_c");
        // subtract
        run_op(5, 3, 0, 1, 2, 0, 0, 0, "sub_5_3");
        run_op(3, 5, 0, 1, 14, 1, 0, 0, "sub_3_5");
        run_op(5, 3, 1, 1, 1, 0, 0, 0, "sub_5_3_b");
        run_op(8, 1, 0, 1, 7, 0, 1, 0, "sub_8_1");
        // stray start during RUN is ignored
        run_op(2, 5, 0, 0, 7, 0, 0, 1, "ignore_start");
        chk("ignore_start_idle", dbg_state, 0);

        // async reset after the 2nd RUN edge
        @(negedge clk);
        a = 4'd6; b = 4'd1; ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_so", so, 0);
        chk("abort_co", co, 0);
        chk("abort_ov", ov, 0);
        chk("abort_state", dbg_state, 0);
        #2 rst_n = 1'b1;
        run_op(1, 1, 0, 0, 2, 0, 0, 0, "after_abort");

        // start held high: back-to-back operations every W+2 cycles
        done_cyc.delete();
        push_exp(7, 0, 0); push_exp(7, 0, 0); push_exp(7, 0, 0);
        @(negedge clk);
        a = 4'd2; b = 4'd5; ci = 1'b0; sub = 1'b0; start = 1'b1;
        begin
            int n;
            n = 0;
            while (done_cyc.size() < 3 && n < 40) begin
                @(negedge clk);
                n++;
                if (done_cyc.size() >= 1 && !done)
                    chk("hold_so_stable", so, 7);
            end
            start = 1'b0;
            chk("hold_done_count", done_cyc.size(), 3);
            if (done_cyc.size() == 3) begin
                chk("hold_period_1", done_cyc[1] - done_cyc[0], 6);
                chk("hold_period_2", done_cyc[2] - done_cyc[1], 6);
            end
        end
        repeat (10) @(negedge clk);

        chk("queue_drained", exp_q.size(), 0);
        chk("done_total", n_done, n_pushed);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
